// File: rtl/mul_share_arbiter_if.sv
// Request/operand and result bus between the two multiply clients and mul_share_arbiter.
// "master" is the client side and "slave" is the arbiter side.
interface mul_share_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic                 req1;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic                 result_id;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, result, result_id
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, result, result_id
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter for two clients sharing one unsigned WIDTHxWIDTH shift-add multiplier.
// One product bit per cycle; every output comes straight from a register.
module mul_share_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    mul_share_arbiter_if.slave bus
);
    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic                gnt0_q, gnt0_d;
    logic                gnt1_q, gnt1_d;
    logic                done_q, done_d;
    logic                id_q, id_d;
    logic [PROD_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [PROD_W-1:0]   mcand_q, mcand_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]    mplier_q, mplier_d;

    logic                any_req;
    logic                win;
    logic [PROD_W-1:0]   acc_step;

    // Contention goes to the pointer; a lone request wins outright.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        win     = (bus.req0 & bus.req1) ? prio_q : bus.req1;
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : {PROD_W{1'b0}});

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done_d   = 1'b0;
        id_d     = id_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = RUN;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    owner_d  = win;
                    prio_d   = ~win;
                    mcand_d  = {{WIDTH{1'b0}}, (win ? bus.a1 : bus.a0)};
                    mplier_d = win ? bus.b1 : bus.b0;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // The final step publishes the sum it has just formed, not acc_q.
                if (cnt_q == LAST_STEP) begin
                    result_d = acc_step;
                    id_d     = owner_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control state: async reset, all updates gated by ena so pulses stretch while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done_q   <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done_q   <= done_d;
            id_q     <= id_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
        end
    end

    // Working datapath is always reloaded at capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (ena) begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_id = id_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter: expected products queued at request time, compared at done.
module tb_mul_share_arbiter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   gnt_cyc = 0;
    int   done_cyc = 0;
    logic [16:0] sb_q[$];

    mul_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mul_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int which);
        which = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            check("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 0);
            check("no_stray_done", 32'(bus.done), 0);
            if (bus.gnt0 | bus.gnt1) begin
                which   = bus.gnt1 ? 1 : 0;
                gnt_cyc = cyc;
                break;
            end
        end
        check("grant_seen", 32'(which >= 0), 1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        logic [16:0] exp;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                break;
            end
            check("gnt_during_run", 32'(bus.gnt0 | bus.gnt1), 0);
        end
        check("done_seen", 32'(seen), 1);
        if (seen) begin
            check("busy_at_done", 32'(bus.busy), 1);
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                check("result", 32'(bus.result), 32'(exp[15:0]));
                check("result_id", 32'(bus.result_id), 32'(exp[16]));
            end else begin
                check("sb_nonempty", sb_q.size(), 1);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_result"}, 32'(bus.result), 0);
        check({tag, "_id"}, 32'(bus.result_id), 0);
    endtask

    initial begin
        int w;
        int g0;
        int rel;
        rst_n = 1'b0;
        ena = 1'b1;
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        // Basic multiply, request present as reset releases
        rst_n = 1'b1; rel = cyc;
        bus.req0 = 1'b1; bus.a0 = 8'd15; bus.b0 = 8'd10;
        sb_q.push_back({1'b0, 16'd150});
        wait_grant(w);
        check("t1_port", w, 0);
        check("t1_first_edge", gnt_cyc - rel, 1);
        bus.req0 = 1'b0;
        wait_done();
        check("t1_latency", done_cyc - gnt_cyc, 8);
        @(negedge clk);
        check("t1_busy_after", 32'(bus.busy), 0);
        check("t1_done_low", 32'(bus.done), 0);
        check("t1_result_hold", 32'(bus.result), 150);

        // Extremes on port 1
        bus.req1 = 1'b1; bus.a1 = 8'd255; bus.b1 = 8'd255;
        sb_q.push_back({1'b1, 16'd65025});
        wait_grant(w);
        check("t2_port", w, 1);
        bus.req1 = 1'b0;
        wait_done();
        bus.req1 = 1'b1; bus.a1 = 8'd0; bus.b1 = 8'd200;
        sb_q.push_back({1'b1, 16'd0});
        wait_grant(w);
        check("t2z_port", w, 1);
        bus.req1 = 1'b0;
        wait_done();
        check("t2z_latency", done_cyc - gnt_cyc, 8);

        // Simultaneous requests straight after reset
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 8'd7;  bus.b0 = 8'd9;
        bus.req1 = 1'b1; bus.a1 = 8'd12; bus.b1 = 8'd12;
        sb_q.push_back({1'b0, 16'd63});
        sb_q.push_back({1'b1, 16'd144});
        wait_grant(w);
        check("t3_first_port", w, 0);
        g0 = gnt_cyc;
        bus.req0 = 1'b0;
        wait_done();
        wait_grant(w);
        check("t3_second_port", w, 1);
        check("t3_gap", gnt_cyc - g0, 10);
        bus.req1 = 1'b0;
        wait_done();

        // Fairness with both requests held
        bus.a0 = 8'd3; bus.b0 = 8'd4; bus.a1 = 8'd5; bus.b1 = 8'd6;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++)
            sb_q.push_back((i % 2) ? {1'b1, 16'd30} : {1'b0, 16'd12});
        for (int i = 0; i < 4; i++) begin
            wait_grant(w);
            check("t4_port", w, i % 2);
            if (i > 0) check("t4_gap", gnt_cyc - g0, 10);
            g0 = gnt_cyc;
            if (i == 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
            wait_done();
        end

        // Reset in the middle of 200*3
        bus.req0 = 1'b1; bus.a0 = 8'd200; bus.b0 = 8'd3;
        wait_grant(w);
        check("t5_port", w, 0);
        bus.req0 = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) begin
            @(negedge clk);
            check("t5_done_in_reset", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.a0 = 8'd5; bus.b0 = 8'd5;
        bus.req1 = 1'b1; bus.a1 = 8'd9; bus.b1 = 8'd9;
        sb_q.push_back({1'b0, 16'd25});
        sb_q.push_back({1'b1, 16'd81});
        wait_grant(w);
        check("t5_prio_reset", w, 0);
        bus.req0 = 1'b0;
        wait_done();
        wait_grant(w);
        check("t5_second", w, 1);
        bus.req1 = 1'b0;
        wait_done();

        // Clock-enable stall during RUN
        bus.req0 = 1'b1; bus.a0 = 8'd13; bus.b0 = 8'd11;
        sb_q.push_back({1'b0, 16'd143});
        wait_grant(w);
        check("t6_port", w, 0);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy_stalled", 32'(bus.busy), 1);
        ena = 1'b1;
        wait_done();
        check("t6_latency", done_cyc - gnt_cyc, 11);
        ena = 1'b0;
        @(negedge clk);
        check("t6_done_stretch", 32'(bus.done), 1);
        ena = 1'b1;
        @(negedge clk);
        check("t6_done_end", 32'(bus.done), 0);
        check("t6_busy_end", 32'(bus.busy), 0);
        check("t6_result_hold", 32'(bus.result), 143);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Two-requester round-robin arbiter and sequencer for one shared unsigned 8x8 iterative shift-add multiplier. Each requester presents two operands and a request. The block grants one requester, captures its operands, and runs the multiply over WIDTH cycles. It then presents the full 2*WIDTH-bit product with a done pulse and the winning requester's ID. It sits between the top-level pin wrapper (operands from ui_in/uio_in, product onto {uo_out, uio_out}) and any internal clients needing a multiply.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock enable; 0 holds every register.
- req0  in  1  requester 0 request; held high until gnt0 is seen.
- a0, b0  in  WIDTH each  requester 0 operands; sampled only at the capture edge.
- req1  in  1  requester 1 request.
- a1, b1  in  WIDTH each  requester 1 operands.
- gnt0, gnt1  out  1 each  registered one-cycle grant pulse for the captured requester.
- busy  out  1  high whenever the FSM is not in IDLE.
- done  out  1  registered one-cycle pulse; result and result_id are valid.
- result  out  2*WIDTH  unsigned product; holds until the next done.
- result_id  out  1  requester that owns result (0 or 1).

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset state is IDLE.
- IDLE with no request: the FSM stays in IDLE.
- IDLE with a request (ena=1, req0 or req1 high): the block picks the winner.
  - One request: that requester wins.
  - Both requests: the priority pointer wins.
- On the capture edge:
  - The winner's a and b go into the multiplicand and multiplier registers.
  - The accumulator and step counter clear.
  - The winner's gnt asserts for the next cycle.
  - The FSM moves to RUN.
  - The priority pointer switches to the other requester.
- RUN: each edge performs one step.
  - If the multiplier LSB is 1, the accumulator adds the multiplicand.
  - The multiplicand shifts left by 1 and the multiplier shifts right by 1.
  - The counter increments.
  - The step with counter = WIDTH-1 loads result, loads result_id, asserts done and moves the FSM to DONE.
- DONE: the FSM returns to IDLE unconditionally on the next edge and done deasserts.
- Arithmetic is fully unsigned. The accumulator is 2*WIDTH bits and cannot overflow (255*255 = 65025).
- Operand or request changes after the capture edge have no effect on the operation in flight.
- A request arriving while busy waits; it is arbitrated at the first IDLE edge.
- A requester that drops req before its grant simply loses. No state is kept per request.
- ena=0 freezes the FSM, the counter, the datapath and the outputs. gnt and done pulses stretch for as long as ena stays low.
- Reset values: gnt0=0, gnt1=0, busy=0, done=0, result=0, result_id=0, priority pointer = requester 0.
- Reset mid-operation abandons the operation in flight: no done pulse and no result update.

## Timing
- Capture at edge E0. gnt is high during cycle E0..E0+1. busy is high from E0 until edge E0+WIDTH+1.
- Result loads at edge E0+WIDTH. done is high for the single cycle E0+WIDTH..E0+WIDTH+1.
- The earliest next capture is edge E0+WIDTH+2, giving 10 cycles per op at WIDTH=8.
- A request held continuously from cycle 0 after reset release is captured at the first edge.
- With both requests held continuously, grants alternate 0,1,0,1,..., each WIDTH+2 cycles apart.
- All outputs are registered, so there is no combinational path from inputs to outputs.

## Test plan
- Basic multiply: req0=1, a0=15, b0=10, after reset, until gnt0 -> gnt0 pulses, done appears 8 cycles after capture, result=150, result_id=0, busy low afterwards.
- Extremes: req1 with 255*255 -> result=65025, result_id=1. Then 0*200 -> result=0, and done still fires after 8 steps.
- Simultaneous requests after reset: req0 (7*9) and req1 (12*12) -> port 0 served first (63, id 0), then port 1 (144, id 1) at capture edge +10.
- Fairness: both req held for 4 ops -> result_id sequence 0,1,0,1. Exactly one gnt per op, and gnt0 and gnt1 are never high together.
- Reset mid-RUN: assert rst_n=0 at step 4 of 200*3 -> all outputs are zero immediately and no done pulse appears. A fresh 5*5 after release gives 25 with port 0 priority.
- ena stall: drop ena for 3 cycles during RUN of 13*11 -> done is delayed by exactly 3 cycles and result=143.
